// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the round-robin mux-select arbiter.
package rr_arb_pkg;

    localparam int N_LANES = 8;
    localparam int SEL_W   = $clog2(N_LANES);

    typedef logic [SEL_W-1:0]   lane_sel_t;
    typedef logic [N_LANES-1:0] lane_vec_t;

    typedef enum logic {IDLE, HOLD} arb_state_t;

    function automatic lane_vec_t onehot(input lane_sel_t s);
        return lane_vec_t'(1) << s;
    endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Circular priority pick: first requesting lane at or after ptr, wrapping mod N_LANES.
module rr_prio_pick
    import rr_arb_pkg::*;
(
    input  lane_vec_t req,
    input  lane_sel_t ptr,
    output logic      found,
    output lane_sel_t idx
);

    logic [2*N_LANES-1:0] dbl;
    lane_vec_t            rot;
    lane_sel_t            off;

    // NOTE: every output of a combinational block gets a value on every path first, so no latch is inferred.
    always_comb begin
        dbl   = {req, req} >> ptr;
        rot   = dbl[N_LANES-1:0];
        found = |rot;
        off   = '0;
        // Descending scan leaves the lowest set offset in off.
        for (int i = N_LANES - 1; i >= 0; i--) begin
            if (rot[i]) off = lane_sel_t'(i);
        end
        idx = ptr + off;
    end

endmodule

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter driving the 8:1 lane mux select with a valid/ready handshake.
module rr_sel_arbiter
    import rr_arb_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  lane_vec_t req,
    output lane_sel_t sel,
    output logic      sel_valid,
    input  logic      sel_ready,
    output lane_vec_t grant,
    output logic      busy
);

    arb_state_t state_q, state_d;
    lane_sel_t  ptr_q, ptr_d;
    lane_sel_t  sel_q, sel_d;
    lane_vec_t  grant_q, grant_d;

    logic       handshake;
    lane_sel_t  pick_ptr;
    logic       pick_found;
    lane_sel_t  pick_idx;

    assign handshake = (state_q == HOLD) && sel_ready;
    // On acceptance the next pick already sees the advanced pointer.
    assign pick_ptr  = handshake ? sel_q + lane_sel_t'(1) : ptr_q;

    rr_prio_pick u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = pick_found ? HOLD : IDLE;
            HOLD:    if (sel_ready) state_d = pick_found ? HOLD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        if (handshake) ptr_d = pick_ptr;
        if ((state_q == IDLE) || handshake) begin
            if (pick_found) begin
                sel_d   = pick_idx;
                grant_d = onehot(pick_idx);
            end else begin
                grant_d = '0;
            end
        end
    end

    assign sel       = sel_q;
    assign grant     = grant_q;
    assign sel_valid = (state_q == HOLD);
    assign busy      = (state_q == HOLD);

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Scoreboard bench: stimulus queues expected accepted grants, a monitor checks each handshake.
module tb_rr_sel_arbiter;
    import rr_arb_pkg::*;

    logic      clk = 1'b0;
    logic      rst = 1'b1;
    lane_vec_t req = '0;
    logic      sel_ready = 1'b0;
    lane_sel_t sel;
    logic      sel_valid;
    lane_vec_t grant;
    logic      busy;

    int n_tests = 0;
    int n_fail  = 0;
    lane_sel_t exp_q[$];

    rr_sel_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .sel       (sel),
        .sel_valid (sel_valid),
        .sel_ready (sel_ready),
        .grant     (grant),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        n_tests++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Inputs only change just after posedge, so negedge values are what the DUT samples next edge.
    always @(negedge clk) begin
        if (!rst && sel_valid && sel_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_handshake", 1, 0);
            end else begin
                lane_sel_t e;
                e = exp_q.pop_front();
                check("hs_sel", int'(sel), int'(e));
                check("hs_grant", int'(grant), int'(onehot(e)));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string name);
        check({name, "_valid"}, int'(sel_valid), 0);
        check({name, "_grant"}, int'(grant), 0);
        check({name, "_busy"}, int'(busy), 0);
    endtask

    // Accept the currently held grant and return to IDLE.
    task automatic drain(input lane_sel_t cur);
        req       = '0;
        sel_ready = 1'b1;
        exp_q.push_back(cur);
        tick();
        sel_ready = 1'b0;
        check_idle("drain");
    endtask

    initial begin
        // 1. Reset with all lanes requesting.
        req = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_idle("reset");
            check("reset_sel", int'(sel), 0);
        end
        rst = 1'b0;
        tick();
        check("post_reset_valid", int'(sel_valid), 1);
        check("post_reset_sel", int'(sel), 0);
        check("post_reset_grant", int'(grant), 8'h01);
        check("post_reset_busy", int'(busy), 1);

        // 2. Rotation 0..7,0 with sel_ready held high.
        for (int i = 0; i < 9; i++) exp_q.push_back(lane_sel_t'(i % 8));
        sel_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            check("rot_valid", int'(sel_valid), 1);
        end
        sel_ready = 1'b0;
        check("rot_next_sel", int'(sel), 1);
        drain(3'd1);

        // 3. Hold stable while req drops.
        req = 8'h20;
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 2) req = '0;
            check("hold_sel", int'(sel), 5);
            check("hold_grant", int'(grant), 8'h20);
            check("hold_valid", int'(sel_valid), 1);
            tick();
        end
        sel_ready = 1'b1;
        exp_q.push_back(3'd5);
        tick();
        sel_ready = 1'b0;
        check_idle("hold_release");
        check("hold_release_sel", int'(sel), 5);

        // 4. Fairness across the wrap (ptr is 6 here).
        req = 8'h40;
        tick();
        check("wrap_first_sel", int'(sel), 6);
        req       = 8'h41;
        sel_ready = 1'b1;
        exp_q.push_back(3'd6);
        exp_q.push_back(3'd0);
        tick();
        check("wrap_after6_sel", int'(sel), 0);
        tick();
        sel_ready = 1'b0;
        check("wrap_after0_sel", int'(sel), 6);
        check("wrap_after0_grant", int'(grant), 8'h40);
        drain(3'd6);

        // 5. Reset mid-grant with a coincident sel_ready.
        req = 8'h08;
        tick();
        check("midrst_grant_sel", int'(sel), 3);
        tick();
        rst       = 1'b1;
        sel_ready = 1'b1;
        req       = 8'h09;
        tick();
        check_idle("midrst");
        check("midrst_sel", int'(sel), 0);
        rst       = 1'b0;
        sel_ready = 1'b0;
        tick();
        check("midrst_first_sel", int'(sel), 0);
        check("midrst_first_grant", int'(grant), 8'h01);
        drain(3'd0);

        // 6. Idle gap then a single high-lane request.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("gap_valid", int'(sel_valid), 0);
        end
        req = 8'h80;
        tick();
        check("gap_end_valid", int'(sel_valid), 1);
        check("gap_end_sel", int'(sel), 7);
        check("gap_end_grant", int'(grant), 8'h80);
        drain(3'd7);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
